// File: rtl/apb_mgr_ctrl.sv
// APB3 requester: turns one valid/ready command into a SETUP/ACCESS transfer
// and returns read data plus error/timeout status on a valid/ready response.
module apb_mgr_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              pclk,
    input  logic              presetn,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,

    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Last wait-count value before the timeout fires; unused when TIMEOUT==0.
    localparam int unsigned     TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_LAST_I);
    localparam logic             TO_EN    = (TIMEOUT != 0);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    // Only combinational output: a new command is taken only from IDLE.
    assign cmd_ready = (state == IDLE);

    // Fires on the TIMEOUT-th consecutive ACCESS cycle without pready.
    assign timeout_hit = TO_EN && (wait_cnt == TO_LAST);

    // Transfer sequencer with registered APB and response outputs.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        pwrite   <= cmd_write;
                        paddr    <= cmd_addr;
                        pwdata   <= cmd_wdata;
                        psel     <= 1'b1;
                        penable  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= SETUP;
                    end
                end

                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end

                ACCESS: begin
                    if (!pready) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                    // pready takes priority over a timeout landing on the same cycle
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else if (timeout_hit) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_mgr_ctrl.sv
// Self-checking bench for apb_mgr_ctrl: transaction-level reference model,
// per-cycle compare, directed scenarios and a randomized soak.
module tb_apb_mgr_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;
    localparam int unsigned CW = 16;

    logic          pclk = 1'b0;
    logic          presetn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          psel, penable, pwrite, pready, pslverr;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;

    int checks = 0;
    int errors = 0;
    logic cmp_on = 1'b0;

    apb_mgr_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transfer is "in flight" from acceptance; m_age counts
    // edges since acceptance, so age 0 is the setup cycle and age k>=1 is the
    // k-th access cycle. A response is then pending until consumed.
    logic          m_xfer, m_pend, m_wr, m_err, m_to;
    int            m_age;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_rd;

    always @(posedge pclk) begin
        if (!presetn) begin
            m_xfer = 0; m_pend = 0; m_age = 0;
            m_wr = 0; m_addr = '0; m_wd = '0;
            m_rd = '0; m_err = 0; m_to = 0;
        end else if (m_pend) begin
            if (rsp_ready) m_pend = 0;
        end else if (!m_xfer) begin
            if (cmd_valid) begin
                m_xfer = 1; m_age = 0;
                m_wr = cmd_write; m_addr = cmd_addr; m_wd = cmd_wdata;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (pready) begin
            m_xfer = 0; m_pend = 1;
            m_rd = m_wr ? '0 : prdata; m_err = pslverr; m_to = 0;
        end else if (TO != 0 && m_age == int'(TO)) begin
            m_xfer = 0; m_pend = 1;
            m_rd = '0; m_err = 1; m_to = 1;
        end else begin
            m_age++;
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge pclk) begin
        if (cmp_on) begin
            chk("cmd_ready",   cmd_ready,   !m_xfer && !m_pend);
            chk("psel",        psel,        m_xfer);
            chk("penable",     penable,     m_xfer && m_age >= 1);
            chk("pwrite",      pwrite,      m_wr);
            chk("paddr",       paddr,       m_addr);
            chk("pwdata",      pwdata,      m_wd);
            chk("rsp_valid",   rsp_valid,   m_pend);
            chk("rsp_rdata",   rsp_rdata,   m_rd);
            chk("rsp_err",     rsp_err,     m_err);
            chk("rsp_timeout", rsp_timeout, m_to);
        end
    end

    // One complete transfer: pready held low for `waits` access cycles, then
    // response held for `hold` cycles with rsp_ready low while a competing
    // command is presented.
    task automatic run_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input int waits, input logic [DW-1:0] rd, input logic se,
                           input int hold, output int pen_n, output int lat, output int rsp_n,
                           output logic [DW-1:0] r_rd, output logic r_err, output logic r_to);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 64) begin
            @(negedge pclk);
            guard++;
        end
        chk("idle_wait", cmd_ready, 1);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
        prdata = rd; pslverr = se; pready = 0; rsp_ready = 0;
        @(negedge pclk);
        cmd_valid = 0; cmd_write = ~wr; cmd_addr = ~a; cmd_wdata = ~wd;
        lat = 1; pen_n = 0;
        while (!rsp_valid && lat < 64) begin
            if (lat == 1) begin
                chk("setup_psel", psel, 1);
                chk("setup_penable", penable, 0);
            end
            if (psel) chk("paddr_hold", paddr, a);
            if (penable) begin
                pen_n++;
                pready = (pen_n > waits);
            end
            @(negedge pclk);
            lat++;
        end
        chk("rsp_wait", rsp_valid, 1);
        r_rd = rsp_rdata; r_err = rsp_err; r_to = rsp_timeout;
        rsp_n = 0;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0000_0FF0; cmd_wdata = 32'h1234_5678;
        pready = 1;
        while (rsp_valid && rsp_n < 64) begin
            rsp_n++;
            rsp_ready = (rsp_n > hold);
            @(negedge pclk);
        end
        cmd_valid = 0; rsp_ready = 0; pready = 0; pslverr = 0;
    endtask

    int pen_n, lat, rsp_n;
    logic [DW-1:0] r_rd;
    logic r_err, r_to;

    initial begin
        presetn = 0; cmd_valid = 1; cmd_write = 1; cmd_addr = 32'hAAAA_0000;
        cmd_wdata = 32'h5555_0000; rsp_ready = 1; pready = 1; prdata = '0; pslverr = 0;

        // Reset held 3 cycles with cmd_valid asserted.
        @(negedge pclk);
        cmp_on = 1;
        @(negedge pclk);
        @(negedge pclk);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        presetn = 1; cmd_valid = 0;
        @(negedge pclk);
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // Zero-wait write.
        run_cmd(1, 32'h0000_0C04, 32'h5, 0, 32'hFFFF_FFFF, 0, 0, pen_n, lat, rsp_n, r_rd, r_err, r_to);
        chk("wr_latency", lat, 3);
        chk("wr_pen_cycles", pen_n, 1);
        chk("wr_rdata", r_rd, 0);
        chk("wr_err", r_err, 0);

        // Read with two wait states.
        run_cmd(0, 32'h0000_0C04, 32'h0, 2, 32'h7, 0, 0, pen_n, lat, rsp_n, r_rd, r_err, r_to);
        chk("rd_pen_cycles", pen_n, 3);
        chk("rd_latency", lat, 5);
        chk("rd_rdata", r_rd, 32'h7);
        chk("rd_err", r_err, 0);

        // Slave error with response backpressure.
        run_cmd(0, 32'h0000_0C10, 32'h0, 0, 32'hDEAD_BEEF, 1, 5, pen_n, lat, rsp_n, r_rd, r_err, r_to);
        chk("err_flag", r_err, 1);
        chk("err_timeout", r_to, 0);
        chk("err_rdata", r_rd, 32'hDEAD_BEEF);
        chk("err_rsp_cycles", rsp_n, 6);

        // Timeout with pready stuck low.
        run_cmd(0, 32'h0000_0C20, 32'h0, 99, 32'h9, 0, 0, pen_n, lat, rsp_n, r_rd, r_err, r_to);
        chk("to_pen_cycles", pen_n, 4);
        chk("to_timeout", r_to, 1);
        chk("to_err", r_err, 1);
        chk("to_rdata", r_rd, 0);

        // pready on the cycle the timeout would fire: pready wins.
        run_cmd(0, 32'h0000_0C24, 32'h0, 3, 32'h11, 0, 0, pen_n, lat, rsp_n, r_rd, r_err, r_to);
        chk("edge_pen_cycles", pen_n, 4);
        chk("edge_timeout", r_to, 0);
        chk("edge_err", r_err, 0);
        chk("edge_rdata", r_rd, 32'h11);

        // Reset during a wait state aborts the transfer.
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h0000_0C08; pready = 0; rsp_ready = 1;
        @(negedge pclk);
        cmd_valid = 0;
        @(negedge pclk);
        @(negedge pclk);
        chk("mid_penable_before", penable, 1);
        presetn = 0;
        @(negedge pclk);
        chk("mid_rst_psel", psel, 0);
        chk("mid_rst_penable", penable, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        presetn = 1;
        @(negedge pclk);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        run_cmd(1, 32'h0000_0C30, 32'hA5, 1, 32'h0, 0, 0, pen_n, lat, rsp_n, r_rd, r_err, r_to);
        chk("after_rst_pen_cycles", pen_n, 2);
        chk("after_rst_err", r_err, 0);

        // Randomized soak checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            presetn   = ($urandom_range(0, 199) != 0);
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_write = 1'($urandom);
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
            pready    = ($urandom_range(0, 9) < 3);
            prdata    = $urandom;
            pslverr   = ($urandom_range(0, 3) == 0);
            rsp_ready = 1'($urandom);
            @(negedge pclk);
        end

        presetn = 1; cmd_valid = 0;
        @(negedge pclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
